// File: rtl/enemy_bullet_pool.sv
// Pool of enemy bullets fired from a moving base toward the fixed-centre ship.
// Each slot latches an 8-way aim at fire time and retires on hit, range or leaving the screen.
module enemy_bullet_pool #(
   parameter int NUM_BULLETS  = 4,
   parameter int BULLET_RANGE = 100,
   parameter int BULLET_SPEED = 2,
   parameter int COOLDOWN     = 30,
   parameter int TRIG_X       = 100,
   parameter int TRIG_Y       = 75,
   parameter int AIM_DEADBAND = 16,
   parameter int BASE_OFF_X   = 32,
   parameter int BASE_OFF_Y   = 36,
   parameter int SHIP_X       = 320,
   parameter int SHIP_Y       = 240
) (
   input  logic                      frame_clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [9:0]                enemy_base_tl_x,
   input  logic [9:0]                enemy_base_tl_y,
   input  logic [NUM_BULLETS-1:0]    hit_clear,
   output logic [10*NUM_BULLETS-1:0] enemy_bullet_x,
   output logic [10*NUM_BULLETS-1:0] enemy_bullet_y,
   output logic [NUM_BULLETS-1:0]    show_bullet,
   output logic                      fire_pulse
);

   localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   localparam logic signed [11:0] SHIP_X_S = 12'(SHIP_X);
   localparam logic signed [11:0] SHIP_Y_S = 12'(SHIP_Y);
   localparam logic signed [11:0] TRIG_X_S = 12'(TRIG_X);
   localparam logic signed [11:0] TRIG_Y_S = 12'(TRIG_Y);
   localparam logic signed [11:0] DB_POS   = 12'(AIM_DEADBAND);
   localparam logic signed [11:0] DB_NEG   = 12'(-AIM_DEADBAND);
   localparam logic signed [11:0] SPD_POS  = 12'(BULLET_SPEED);
   localparam logic signed [11:0] SPD_NEG  = 12'(-BULLET_SPEED);
   localparam logic signed [11:0] X_MAX    = 12'sd639;
   localparam logic signed [11:0] Y_MAX    = 12'sd479;
   localparam logic [9:0]         RANGE    = 10'(BULLET_RANGE);
   localparam logic [9:0]         STEP     = 10'(BULLET_SPEED);

   typedef enum logic {IDLE, FLIGHT} slot_state_t;

   logic [10:0]            cx;
   logic [10:0]            cy;
   logic signed [11:0]     dx;
   logic signed [11:0]     dy;
   logic signed [11:0]     adx;
   logic signed [11:0]     ady;
   logic signed [11:0]     aim_vx;
   logic signed [11:0]     aim_vy;
   logic                   in_window;
   logic                   fire;
   logic [NUM_BULLETS-1:0] idle;
   logic [NUM_BULLETS-1:0] load_sel;
   logic [CD_W-1:0]        cooldown_reg;
   logic                   fire_pulse_reg;

   // Deltas are formed in signed 12-bit so a base right/below of the ship never wraps.
   assign cx  = {1'b0, enemy_base_tl_x} + 11'(BASE_OFF_X);
   assign cy  = {1'b0, enemy_base_tl_y} + 11'(BASE_OFF_Y);
   assign dx  = SHIP_X_S - $signed({1'b0, cx});
   assign dy  = SHIP_Y_S - $signed({1'b0, cy});
   assign adx = dx[11] ? -dx : dx;
   assign ady = dy[11] ? -dy : dy;

   assign in_window = (adx <= TRIG_X_S) && (ady <= TRIG_Y_S);

   assign aim_vx = (dx >= DB_POS) ? SPD_POS : ((dx <= DB_NEG) ? SPD_NEG : 12'sd0);
   assign aim_vy = (dy >= DB_POS) ? SPD_POS : ((dy <= DB_NEG) ? SPD_NEG : 12'sd0);

   // Isolate the lowest idle slot; idle reflects slot state before this edge.
   assign load_sel = idle & (~idle + NUM_BULLETS'(1));
   assign fire     = enable && in_window && (cooldown_reg == '0) && (|idle);

   always_ff @(posedge frame_clk) begin
      if (!reset_n) begin
         cooldown_reg   <= '0;
         fire_pulse_reg <= 1'b0;
      end else begin
         fire_pulse_reg <= fire;
         if (fire)
            cooldown_reg <= CD_W'(COOLDOWN);
         else if (cooldown_reg != '0)
            cooldown_reg <= cooldown_reg - CD_W'(1);
      end
   end

   assign fire_pulse = fire_pulse_reg;

   generate
      for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
         slot_state_t        state_reg;
         logic [9:0]         x_reg;
         logic [9:0]         y_reg;
         logic [9:0]         dist_reg;
         logic signed [11:0] vx_reg;
         logic signed [11:0] vy_reg;
         logic signed [11:0] x_next;
         logic signed [11:0] y_next;
         logic               off_screen;

         assign x_next     = $signed({2'b00, x_reg}) + vx_reg;
         assign y_next     = $signed({2'b00, y_reg}) + vy_reg;
         assign off_screen = (x_next < 12'sd0) || (x_next > X_MAX) ||
                             (y_next < 12'sd0) || (y_next > Y_MAX);

         // A load takes precedence over any retirement reason, including hit_clear.
         always_ff @(posedge frame_clk) begin
            if (!reset_n) begin
               state_reg <= IDLE;
               x_reg     <= '0;
               y_reg     <= '0;
               dist_reg  <= '0;
               vx_reg    <= '0;
               vy_reg    <= '0;
            end else if (fire && load_sel[gi]) begin
               state_reg <= FLIGHT;
               x_reg     <= cx[9:0];
               y_reg     <= cy[9:0];
               dist_reg  <= '0;
               vx_reg    <= aim_vx;
               vy_reg    <= aim_vy;
            end else if (state_reg == FLIGHT) begin
               if (hit_clear[gi] || (dist_reg >= RANGE) || off_screen) begin
                  state_reg <= IDLE;
               end else begin
                  x_reg    <= x_next[9:0];
                  y_reg    <= y_next[9:0];
                  dist_reg <= dist_reg + STEP;
               end
            end
         end

         assign idle[gi]                   = (state_reg == IDLE);
         assign show_bullet[gi]            = (state_reg == FLIGHT);
         assign enemy_bullet_x[10*gi +: 10] = x_reg;
         assign enemy_bullet_y[10*gi +: 10] = y_reg;
      end
   endgenerate

endmodule

// File: doc/enemy_bullet_pool.md
Name: enemy_bullet_pool

Overview:
- Parametrised successor to the single-shot enemy base gun.
- Manages a pool of NUM_BULLETS independent enemy bullets fired from one moving enemy base at the fixed-centre player ship.
- Adds 8-direction aiming latched at fire time, a fire cooldown, per-slot hit clearing and off-screen retirement.
- Sits between the enemy base position logic and the colour mapper / collision logic; advances once per frame_clk.

Parameters:
- NUM_BULLETS, 4, number of bullet slots (1..8).
- BULLET_RANGE, 100, travel distance per axis before retirement (max 511).
- BULLET_SPEED, 2, pixels moved per frame on each active axis.
- COOLDOWN, 30, frames between fires.
- TRIG_X, 100, horizontal half-width of the trigger window.
- TRIG_Y, 75, vertical half-height of the trigger window.
- AIM_DEADBAND, 16, an axis whose |delta| is below this gets zero velocity.
- BASE_OFF_X, 32, base centre offset from its top-left corner in X.
- BASE_OFF_Y, 36, base centre offset from its top-left corner in Y.
- SHIP_X, 320, ship centre X.
- SHIP_Y, 240, ship centre Y.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  permits new fires; bullets already in flight continue regardless.
- enemy_base_tl_x  in  10  base top-left X, unsigned.
- enemy_base_tl_y  in  10  base top-left Y, unsigned.
- hit_clear  in  NUM_BULLETS  per-slot kill request (collision).
- enemy_bullet_x  out  10*NUM_BULLETS  slot i X at bits [10i+9:10i].
- enemy_bullet_y  out  10*NUM_BULLETS  slot i Y at bits [10i+9:10i].
- show_bullet  out  NUM_BULLETS  slot i active.
- fire_pulse  out  1  high for the one frame in which a fire occurs.

Behaviour:
- Reset (reset_n=0 at an edge), including mid-flight:
  - all outputs are 0: positions, show_bullet, fire_pulse;
  - per-slot distance counters and velocities are 0;
  - cooldown counter is 0.
- Centre: cx = tl_x + BASE_OFF_X, cy = tl_y + BASE_OFF_Y, computed 11-bit.
- Deltas: dx = SHIP_X - cx and dy = SHIP_Y - cy, signed 12-bit. No unsigned underflow is permitted.
- in_window = |dx| <= TRIG_X and |dy| <= TRIG_Y.
- Fire condition: enable & in_window & cooldown==0 & at least one slot idle at the start of the cycle.
- On fire:
  - the lowest-index idle slot loads position (cx, cy), dist=0 and show=1;
  - velocity is latched: vx = +SPEED if dx >= AIM_DEADBAND, -SPEED if dx <= -AIM_DEADBAND, else 0; vy likewise from dy;
  - cooldown loads COOLDOWN;
  - fire_pulse=1 that cycle.
- Cooldown: decrements by 1 each frame while nonzero. Consecutive fires under a held trigger are spaced COOLDOWN+1 frames apart. With COOLDOWN=0, a fire can occur every frame.
- Per-slot state machine IDLE -> FLIGHT -> IDLE. Each FLIGHT cycle is evaluated in priority order:
  1. hit_clear[i]=1 -> IDLE.
  2. dist >= BULLET_RANGE -> IDLE.
  3. Next position (signed 12-bit) outside X 0..639 or Y 0..479 -> IDLE; the position register holds its last value.
  4. Otherwise x += vx, y += vy, dist += BULLET_SPEED. dist is a 10-bit counter.
- On retirement, show=0 and position holds its last value.
- A bullet with vx=vy=0 (ship at base centre) stays stationary and retires by range count only.
- A slot retiring in cycle t becomes available for fire at t+1, not t.
- hit_clear on an IDLE slot is ignored. hit_clear on the slot being loaded in the same cycle is ignored; the fire wins.
- Bullets move in absolute screen coordinates, independent of later base motion.

Test Plan:
- Aim/flight: defaults, tl=(250,180), so centre=(282,216), dx=38, dy=24 -> fire_pulse for 1 frame; slot0 at (282,216), then (284,218); after 50 moves slot0 is at (382,316) with dist=100; show_bullet[0] drops on the 51st frame after fire.
- Cooldown: defaults, base held at (250,180) -> fire_pulse at frames 0, 31, 62; slots 0, 1, 0 used (slot0 is free again by frame 62).
- Exhaustion: NUM_BULLETS=4, COOLDOWN=0, BULLET_RANGE=511, base in window -> fires on 4 consecutive frames into slots 0..3; no fire_pulse on the 5th frame; hit_clear=4'b0100 -> next frame slot2 refires.
- Off-screen: SHIP_X=10, tl=(0,204), so centre=(32,240), dx=-22, dy=0 -> x steps 32,30,...,0 over 16 frames; the 17th frame retires the slot at x=0 with show=0.
- Window edge: tl=(188,180), so cx=220, |dx|=100 -> fires; tl=(187,180) -> |dx|=101 -> no fire. Low enable also blocks firing while bullets in flight keep moving.
- Reset mid-flight: two bullets active and cooldown=12, assert reset_n=0 for 1 frame -> all outputs 0 next edge; the first fire after release occurs immediately if in window.
